// File: rtl/exec_cc_gen_pkg.sv
// Shared constants for the execute stage: instruction codes, ALU function codes,
// condition codes and the condition-code flag layout.
package exec_cc_gen_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_CMOVXX = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3
  } alu_fn_e;

  typedef enum logic [3:0] {
    C_YES = 4'h0,
    C_LE  = 4'h1,
    C_L   = 4'h2,
    C_E   = 4'h3,
    C_NE  = 4'h4,
    C_GE  = 4'h5,
    C_G   = 4'h6
  } cond_e;

  // Bit positions inside the packed {ZF,SF,OF} flag vector.
  localparam int ZF = 2;
  localparam int SF = 1;
  localparam int OF = 0;

  // Flags the CC register comes out of reset with; must match the register's own reset.
  localparam logic [2:0] CC_RST = 3'b100;

endpackage

// File: rtl/exec_cc_gen_if.sv
// Condition-code write port: the execute stage drives new flags and a write enable,
// the CC register consumes them.
interface exec_cc_gen_if;
  logic [2:0] newCC;
  logic       setCC;

  modport master (output newCC, output setCC);
  modport slave  (input  newCC, input  setCC);
endinterface

// File: rtl/exec_cc_gen_alu_core.sv
// Combinational W-bit ALU: result = b OP a, plus {ZF,SF,OF} derived from that result.
module exec_cc_gen_alu_core
  import exec_cc_gen_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [3:0]   fn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] val,
  output logic [2:0]   cc
);

  logic of;

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise unlisted function codes would infer a latch.
  always_comb begin
    val = '0;
    of  = 1'b0;
    case (fn)
      ALU_ADD: begin
        val = b + a;
        of  = (a[W-1] == b[W-1]) && (val[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        val = b - a;
        of  = (a[W-1] != b[W-1]) && (val[W-1] != b[W-1]);
      end
      ALU_AND: val = b & a;
      ALU_XOR: val = b ^ a;
      default: val = '0;
    endcase
  end

  assign cc[ZF] = (val == '0);
  assign cc[SF] = val[W-1];
  assign cc[OF] = of;

endmodule

// File: rtl/exec_cc_gen.sv
// Execute stage: ALU, condition-code commit to the CC register, and the E->M
// pipeline register.
module exec_cc_gen
  import exec_cc_gen_pkg::*;
#(
  parameter int W = 64
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [3:0]     E_icode,
  input  logic [3:0]     E_ifun,
  input  logic [W-1:0]   aluA,
  input  logic [W-1:0]   aluB,
  input  logic           E_Cnd,
  input  logic           m_exc,
  input  logic           W_exc,
  input  logic           M_stall,
  input  logic           M_bubble,
  exec_cc_gen_if.master  cc,
  output logic [W-1:0]   e_valE,
  output logic [3:0]     M_icode,
  output logic [W-1:0]   M_valE,
  output logic           M_Cnd
);

  logic [3:0] alu_fn;
  logic       is_opq;

  assign is_opq = (E_icode == I_OPQ);

  // Anything other than OPq is address or stack arithmetic, which is always an add.
  always_comb begin
    alu_fn = ALU_ADD;
    if (is_opq) alu_fn = E_ifun;
  end

  exec_cc_gen_alu_core #(.W(W)) u_alu_core (
    .fn  (alu_fn),
    .a   (aluA),
    .b   (aluB),
    .val (e_valE),
    .cc  (cc.newCC)
  );

  // The CC register latches on the same edge, so a dependent branch or cmov in E
  // the next cycle already sees these flags. M_stall deliberately does not gate this.
  assign cc.setCC = is_opq && (E_ifun <= ALU_XOR) && !m_exc && !W_exc && !reset;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset || M_bubble) begin
      M_icode <= I_NOP;
      M_valE  <= '0;
      M_Cnd   <= 1'b0;
    end else if (!M_stall) begin
      M_icode <= E_icode;
      M_valE  <= e_valE;
      M_Cnd   <= E_Cnd;
    end
  end

endmodule

// File: tb/tb_exec_cc_gen.sv
// Scoreboard bench for exec_cc_gen: the driver pushes expected responses from a
// behavioural model, a monitor pops and compares them every clock.
module tb_exec_cc_gen;

  logic        clock;
  logic        reset;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] aluA;
  logic [63:0] aluB;
  logic        E_Cnd;
  logic        m_exc;
  logic        W_exc;
  logic        M_stall;
  logic        M_bubble;
  logic [63:0] e_valE;
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic        M_Cnd;

  exec_cc_gen_if cc_bus ();

  exec_cc_gen #(.W(64)) dut (
    .clock    (clock),
    .reset    (reset),
    .E_icode  (E_icode),
    .E_ifun   (E_ifun),
    .aluA     (aluA),
    .aluB     (aluB),
    .E_Cnd    (E_Cnd),
    .m_exc    (m_exc),
    .W_exc    (W_exc),
    .M_stall  (M_stall),
    .M_bubble (M_bubble),
    .cc       (cc_bus),
    .e_valE   (e_valE),
    .M_icode  (M_icode),
    .M_valE   (M_valE),
    .M_Cnd    (M_Cnd)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] vale;
    logic [2:0]  cc;
    logic        setcc;
    logic        chk_cc;
  } comb_t;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] vale;
    logic        cnd;
  } mreg_t;

  comb_t comb_q[$];
  mreg_t mreg_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Architectural view of the E->M register, advanced once per issued cycle.
  logic [3:0]  exp_icode = 4'h1;
  logic [63:0] exp_vale  = '0;
  logic        exp_cnd   = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: plain two's-complement arithmetic; overflow means the exact signed
  // result does not fit in 64 bits.
  function automatic comb_t model_comb(input logic [3:0] ic, input logic [3:0] fn,
                                       input logic [63:0] a, input logic [63:0] b,
                                       input logic mx, input logic wx, input logic rs);
    comb_t r;
    logic signed [64:0] exact;
    logic of;
    of       = 1'b0;
    r.chk_cc = 1'b0;
    if (ic != 4'h6) begin
      r.vale = b + a;
    end else begin
      r.chk_cc = (fn <= 4'd3);
      case (fn)
        4'd0: begin
          exact  = $signed({b[63], b}) + $signed({a[63], a});
          r.vale = exact[63:0];
          of     = (exact > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (exact < -65'sh0_8000_0000_0000_0000);
        end
        4'd1: begin
          exact  = $signed({b[63], b}) - $signed({a[63], a});
          r.vale = exact[63:0];
          of     = (exact > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (exact < -65'sh0_8000_0000_0000_0000);
        end
        4'd2:    r.vale = b & a;
        4'd3:    r.vale = b ^ a;
        default: r.vale = '0;
      endcase
    end
    r.cc    = {(r.vale == 64'd0), r.vale[63], of};
    r.setcc = (ic == 4'h6) && (fn <= 4'd3) && !mx && !wx && !rs;
    return r;
  endfunction

  task automatic step(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic cnd,
                      input logic mx, input logic wx, input logic stall,
                      input logic bubble, input logic rs);
    comb_t c;
    mreg_t m;
    @(negedge clock);
    E_icode  = ic;
    E_ifun   = fn;
    aluA     = a;
    aluB     = b;
    E_Cnd    = cnd;
    m_exc    = mx;
    W_exc    = wx;
    M_stall  = stall;
    M_bubble = bubble;
    reset    = rs;
    c = model_comb(ic, fn, a, b, mx, wx, rs);
    comb_q.push_back(c);
    if (rs || bubble) begin
      exp_icode = 4'h1;
      exp_vale  = '0;
      exp_cnd   = 1'b0;
    end else if (!stall) begin
      exp_icode = ic;
      exp_vale  = c.vale;
      exp_cnd   = cnd;
    end
    m.icode = exp_icode;
    m.vale  = exp_vale;
    m.cnd   = exp_cnd;
    mreg_q.push_back(m);
  endtask

  // Monitor: combinational outputs just before the edge, registered outputs just after.
  initial begin
    comb_t c;
    mreg_t m;
    forever begin
      @(posedge clock);
      if (comb_q.size() == 0) begin
        check("comb_queue_nonempty", 64'd0, 64'd1);
      end else begin
        c = comb_q.pop_front();
        check("e_valE", e_valE, c.vale);
        check("setCC", {63'd0, cc_bus.setCC}, {63'd0, c.setcc});
        if (c.chk_cc) check("newCC", {61'd0, cc_bus.newCC}, {61'd0, c.cc});
      end
      #1;
      if (mreg_q.size() == 0) begin
        check("mreg_queue_nonempty", 64'd0, 64'd1);
      end else begin
        m = mreg_q.pop_front();
        check("M_icode", {60'd0, M_icode}, {60'd0, m.icode});
        check("M_valE", M_valE, m.vale);
        check("M_Cnd", {63'd0, M_Cnd}, {63'd0, m.cnd});
      end
    end
  end

  function automatic logic [63:0] pick_operand();
    logic [63:0] corners [6];
    corners[0] = 64'd0;
    corners[1] = 64'd1;
    corners[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    corners[3] = 64'h8000_0000_0000_0000;
    corners[4] = 64'h7FFF_FFFF_FFFF_FFFF;
    corners[5] = 64'h4000_0000_0000_0000;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    reset = 1'b1; E_icode = 4'h1; E_ifun = 4'h0; aluA = '0; aluB = '0; E_Cnd = 1'b0;
    m_exc = 1'b0; W_exc = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;

    // Reset held for two cycles with live-looking E inputs.
    step(4'h6, 4'h0, 64'd3, 64'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'h6, 4'h1, 64'd3, 64'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // sub to zero, add signed overflow, sub overflow with and without m_exc.
    step(4'h6, 4'h1, 64'd5, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000,
         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Address add, then a two-cycle stall while E keeps changing.
    step(4'h5, 4'h0, 64'd8, 64'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'h6, 4'h2, 64'hF0, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(4'h3, 4'h0, 64'd9, 64'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // Bubble beats stall; the xor still commits flags.
    step(4'h6, 4'h3, 64'hA5, 64'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    // Invalid OPq function code and a W-stage exception.
    step(4'h6, 4'h7, 64'd2, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'h6, 4'h0, 64'd2, 64'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] ic;
      logic [3:0] fn;
      ic = ($urandom_range(0, 1) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      fn = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      step(ic, fn, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 39) == 0));
    end

    @(posedge clock);
    #3;
    check("queues_drained", 64'(comb_q.size() + mreg_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
